// File: rtl/instr_fetch_seq.sv
// Fetch sequencer for the multi-cycle core: reads instruction (and mvi immediate)
// words from a synchronous RAM and presents them on DIN when the core samples them.
module instr_fetch_seq #(
    parameter int          ADDR_W  = 6,
    parameter int          MEM_LAT = 1,
    parameter logic [2:0]  MVI_OP  = 3'b001
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic              Done,
    input  logic [15:0]       MemData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       DIN,
    output logic              ProcHold,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic [2:0]        State
);

    // Handshake: the core only runs while ProcHold=0; Done is honoured only in EXEC,
    // and Run is sampled only in IDLE and on the Done cycle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_IMM   = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    localparam logic [1:0] LAT = 2'(MEM_LAT);

    state_t            state;
    logic [1:0]        cnt;
    logic [15:0]       instr_q;
    logic [15:0]       imm_q;
    logic              is_mvi;
    logic [ADDR_W-1:0] pc_next;

    assign is_mvi  = (instr_q[8:6] == MVI_OP);
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign pc_next = PC + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));

    assign Busy  = (state != S_IDLE);
    assign State = state;

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state    <= S_IDLE;
            PC       <= '0;
            MemAddr  <= '0;
            instr_q  <= '0;
            imm_q    <= '0;
            DIN      <= '0;
            ProcHold <= 1'b1;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ProcHold <= 1'b1;
                    if (Run) begin
                        MemAddr <= PC;
                        cnt     <= '0;
                        state   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (cnt == LAT) begin
                        instr_q <= MemData;
                        cnt     <= '0;
                        if (MemData[8:6] == MVI_OP) begin
                            MemAddr <= PC + ADDR_W'(1);
                            state   <= S_IMM;
                        end else begin
                            // Registered so DIN/ProcHold are valid for the whole ISSUE cycle.
                            DIN      <= MemData;
                            ProcHold <= 1'b0;
                            state    <= S_ISSUE;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end

                S_IMM: begin
                    if (cnt == LAT) begin
                        imm_q    <= MemData;
                        cnt      <= '0;
                        DIN      <= instr_q;
                        ProcHold <= 1'b0;
                        state    <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end

                S_ISSUE: begin
                    DIN   <= is_mvi ? imm_q : instr_q;
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    if (Done) begin
                        PC       <= pc_next;
                        ProcHold <= 1'b1;
                        cnt      <= '0;
                        if (Run) begin
                            MemAddr <= pc_next;
                            state   <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: one instance at MEM_LAT=1 running a small
// program, a second at MEM_LAT=3 for the long-fetch case.
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, done, run3, done3;
    logic [15:0] mem_data, mem_data3;
    logic [5:0]  mem_addr, mem_addr3;
    logic [15:0] din, din3;
    logic        hold, hold3, busy, busy3;
    logic [5:0]  pc, pc3;
    logic [2:0]  state, state3;

    logic [15:0] ram1 [64];
    logic [15:0] ram3 [64];
    logic [15:0] d3a, d3b;

    int total = 0;
    int passed = 0;
    int guard;

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(6), .MEM_LAT(1), .MVI_OP(3'b001)) u_dut (
        .Clock(clk), .Resetn(rst), .Run(run), .Done(done), .MemData(mem_data),
        .MemAddr(mem_addr), .DIN(din), .ProcHold(hold), .PC(pc), .Busy(busy), .State(state)
    );

    instr_fetch_seq #(.ADDR_W(6), .MEM_LAT(3), .MVI_OP(3'b001)) u_dut3 (
        .Clock(clk), .Resetn(rst), .Run(run3), .Done(done3), .MemData(mem_data3),
        .MemAddr(mem_addr3), .DIN(din3), .ProcHold(hold3), .PC(pc3), .Busy(busy3), .State(state3)
    );

    // Synchronous RAM models: one and three register stages of read latency.
    always @(posedge clk) begin
        mem_data <= ram1[mem_addr];
        d3a      <= ram3[mem_addr3];
        d3b      <= d3a;
        mem_data3 <= d3b;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Let the running instruction reach EXEC, then pulse Done for one cycle.
    task automatic run_instr1();
        for (int i = 0; i < 20 && state != 3'd4; i++) step();
        chk("wait_exec", 32'(state), 4);
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram1[i] = 16'h0008;
            ram3[i] = 16'h0008;
        end
        ram1[0] = 16'h0008;  // mv R1,R0
        ram1[1] = 16'h0040;  // mvi R0
        ram1[2] = 16'h1234;  // immediate
        ram1[3] = 16'h0081;  // add R0,R1
        rst = 1'b1; run = 1'b0; done = 1'b0; run3 = 1'b0; done3 = 1'b0;
        step();
        step();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_hold", 32'(hold), 1);
        chk("rst_state", 32'(state), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_busy", 32'(busy), 0);

        // mv at address 0: IDLE, FETCH x2, ISSUE on the fourth cycle
        rst = 1'b0; run = 1'b1;
        step();
        chk("mv_fetch0", 32'(state), 1);
        chk("mv_addr", 32'(mem_addr), 0);
        step();
        chk("mv_fetch1", 32'(state), 1);
        step();
        chk("mv_issue", 32'(state), 3);
        chk("mv_issue_din", 32'(din), 32'h0008);
        chk("mv_issue_hold", 32'(hold), 0);
        step();
        chk("mv_exec", 32'(state), 4);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("mv_pc", 32'(pc), 1);
        chk("mv_next_state", 32'(state), 1);
        chk("mv_next_addr", 32'(mem_addr), 1);
        chk("mv_next_hold", 32'(hold), 1);

        // mvi at address 1 with immediate at address 2
        step();
        step();
        chk("mvi_imm_state", 32'(state), 2);
        chk("mvi_imm_addr", 32'(mem_addr), 2);
        step();
        step();
        chk("mvi_issue", 32'(state), 3);
        chk("mvi_issue_din", 32'(din), 32'h0040);
        step();
        chk("mvi_exec_din", 32'(din), 32'h1234);
        chk("mvi_exec_hold", 32'(hold), 0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("mvi_pc", 32'(pc), 3);
        chk("mvi_next_addr", 32'(mem_addr), 3);

        // add at address 3; a stray Done during FETCH must be ignored
        done = 1'b1;
        step();
        done = 1'b0;
        chk("stray_done_pc", 32'(pc), 3);
        chk("stray_done_state", 32'(state), 1);
        step();
        chk("add_issue_din", 32'(din), 32'h0081);
        chk("add_issue_hold", 32'(hold), 0);
        step();
        chk("add_exec1_hold", 32'(hold), 0);
        chk("add_exec1_pc", 32'(pc), 3);
        step();
        chk("add_exec2_hold", 32'(hold), 0);
        chk("add_exec2_state", 32'(state), 4);
        step();
        chk("add_exec3_pc", 32'(pc), 3);
        chk("add_exec3_din", 32'(din), 32'h0081);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("add_pc", 32'(pc), 4);
        chk("add_next_hold", 32'(hold), 1);

        // Run dropped during FETCH at PC=4: instruction completes, then IDLE
        run = 1'b0;
        step();
        step();
        chk("drop_issue", 32'(state), 3);
        chk("drop_issue_din", 32'(din), 32'h0008);
        chk("drop_busy", 32'(busy), 1);
        step();
        chk("drop_exec", 32'(state), 4);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("drop_idle", 32'(state), 0);
        chk("drop_pc", 32'(pc), 5);
        chk("drop_hold", 32'(hold), 1);
        chk("drop_idle_busy", 32'(busy), 0);
        step();
        chk("drop_stay_idle", 32'(state), 0);

        // Reset in the middle of EXEC at PC=5, coinciding with Done
        run = 1'b1;
        step();
        step();
        step();
        step();
        chk("pre_rst_state", 32'(state), 4);
        chk("pre_rst_pc", 32'(pc), 5);
        rst = 1'b1; done = 1'b1; run = 1'b0;
        step();
        rst = 1'b0; done = 1'b0;
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_hold", 32'(hold), 1);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_din", 32'(din), 0);

        // Walk to PC=63 holding an mvi whose immediate wraps to address 0
        ram1[0]  = 16'h00FF;
        ram1[63] = 16'h0040;
        run = 1'b1;
        guard = 0;
        while (pc != 6'd63 && guard < 80) begin
            run_instr1();
            guard++;
        end
        chk("wrap_pc", 32'(pc), 63);
        chk("wrap_addr", 32'(mem_addr), 63);
        step();
        step();
        chk("wrap_imm_state", 32'(state), 2);
        chk("wrap_imm_addr", 32'(mem_addr), 0);
        step();
        step();
        chk("wrap_issue_din", 32'(din), 32'h0040);
        step();
        chk("wrap_exec_din", 32'(din), 32'h00FF);
        done = 1'b1;
        step();
        done = 1'b0;
        run = 1'b0;
        chk("wrap_next_pc", 32'(pc), 1);
        chk("wrap_next_addr", 32'(mem_addr), 1);

        // MEM_LAT=3 instance: FETCH spans four cycles, Run dropped during it
        run3 = 1'b1;
        step();
        run3 = 1'b0;
        chk("lat3_fetch0", 32'(state3), 1);
        chk("lat3_addr", 32'(mem_addr3), 0);
        step();
        step();
        step();
        chk("lat3_fetch3", 32'(state3), 1);
        chk("lat3_fetch3_hold", 32'(hold3), 1);
        step();
        chk("lat3_issue", 32'(state3), 3);
        chk("lat3_issue_din", 32'(din3), 32'h0008);
        step();
        chk("lat3_exec", 32'(state3), 4);
        done3 = 1'b1;
        step();
        done3 = 1'b0;
        chk("lat3_idle", 32'(state3), 0);
        chk("lat3_pc", 32'(pc3), 1);
        chk("lat3_busy", 32'(busy3), 0);
        chk("lat3_hold", 32'(hold3), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Fetch sequencer upstream of the multi-cycle processor core.
- Drives the synchronous instruction RAM address and captures instruction words.
- For mvi, prefetches the immediate word as well.
- Presents words on the core's DIN exactly when the core samples them (IR at Ciclo 0, immediate at Ciclo 1).
- Holds the core's step counter in cycle 0 while memory is being read, replacing the free-running PC counter.

Parameters:
- ADDR_W, 6, instruction memory address width; PC wraps modulo 2^ADDR_W.
- MEM_LAT, 1, RAM read latency in cycles (1..3); data for the address driven at edge t is valid after edge t+MEM_LAT.
- MVI_OP, 3'b001, opcode field value (word bits [8:6]) that needs a second (immediate) word.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-high reset (1 = reset).
- Run  in  1  fetch enable; sampled only in IDLE and at instruction completion.
- Done  in  1  core's instruction-complete strobe (combinational from core).
- MemData  in  16  RAM read data.
- MemAddr  out  ADDR_W  registered RAM address.
- DIN  out  16  word presented to core.
- ProcHold  out  1  high = force core step counter to 0 (OR'd into core Clear).
- PC  out  ADDR_W  address of the current instruction (for HEX display).
- Busy  out  1  high in every state except IDLE.
- State  out  3  encoded FSM state for display/debug.

Behaviour:
- All outputs registered or decoded from registered state; no combinational Run/Done→output path except next-state.
- Reset (any state, any cycle, including mid-fetch or mid-execute), applied next edge: state=IDLE, PC=0, MemAddr=0, instr_q=0, imm_q=0, DIN=0, ProcHold=1, Busy=0, latency counter=0.
- States (State code):
  - IDLE(0): ProcHold=1. Run=1 → FETCH with MemAddr=PC, cnt=0.
  - FETCH(1): cnt increments each cycle. When cnt==MEM_LAT, capture instr_q=MemData. If MemData[8:6]==MVI_OP, then MemAddr=PC+1 (wrapping) and → IMM; else → ISSUE. Duration MEM_LAT+1 cycles.
  - IMM(2): same counting. At cnt==MEM_LAT capture imm_q=MemData, → ISSUE.
  - ISSUE(3): ProcHold=0, DIN=instr_q for exactly one cycle; the core latches IR on this cycle's closing edge. → EXEC.
  - EXEC(4): ProcHold=0. DIN=imm_q if instr is mvi, else instr_q. Wait for Done=1.
    - On Done: PC += 1, or += 2 for mvi (modulo 2^ADDR_W). ProcHold=1 from the next cycle.
    - Then Run=1 → FETCH with MemAddr=new PC; Run=0 → IDLE.
- Latency, MEM_LAT=1, measured from IDLE with Run=1:
  - non-mvi: IDLE 1 + FETCH 2 + ISSUE 1, then EXEC until Done (add: 3 cycles).
  - mvi: FETCH 2 + IMM 2 + ISSUE 1 + EXEC 1.
- Done outside EXEC is ignored (no PC change).
- Run falling during FETCH/IMM/ISSUE/EXEC: the current instruction completes, then → IDLE; it never aborts mid-instruction.
- Wrap: PC=2^ADDR_W-1 non-mvi → PC=0. mvi at last address fetches its immediate from address 0; next PC=1.
- Done and Resetn in the same cycle: reset wins.
- DIN holds its last value in FETCH/IMM/IDLE; the core is held, so the value is don't-care there.

Test Plan:
1. Reset mid-EXEC (PC=5): assert Resetn 1 cycle → next cycle PC=0, MemAddr=0, ProcHold=1, State=0, DIN=0.
2. RAM[0]=mv R1,R0 (16'h0008), Run=1, MEM_LAT=1:
   - ISSUE on cycle 4 with DIN=16'h0008, ProcHold=0.
   - Done in EXEC cycle 1 → PC=1, State=FETCH, MemAddr=1.
3. RAM[0]=mvi R0 (16'h0040), RAM[1]=16'h1234:
   - ISSUE DIN=16'h0040, then EXEC DIN=16'h1234.
   - Done → PC=2; core R0=16'h1234.
4. RAM[3]=add R0,R1 (16'h0081):
   - EXEC lasts 3 cycles.
   - ProcHold stays 0 through ISSUE+EXEC.
   - PC 3→4 only on the Done cycle.
5. ADDR_W=6, PC=63 holding mvi, RAM[0]=16'h00FF → immediate 16'h00FF on DIN, next PC=1.
6. Run dropped during FETCH at PC=2 (non-mvi) → instruction still issues and completes, PC=3, then IDLE with ProcHold=1 and Busy=0.
   - Repeat with MEM_LAT=3 → FETCH lasts 4 cycles.
